// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of the hazard sources and the stage-register controls
// exchanged between the pipeline datapath and pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if;
  logic [4:0]  rs_rr;
  logic [4:0]  rt_rr;
  logic        use_rs_rr;
  logic        use_rt_rr;
  logic        memread_ex;
  logic [4:0]  dest_ex;
  logic        jump_ex;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_en;
  logic        ifid_en;
  logic        idrr_en;
  logic        rrex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idrr_flush;
  logic        rrex_bubble;
  logic        memwb_bubble;
  logic        pc_sel_jump;
  logic [15:0] stall_cycles;
  logic        mem_timeout;

  // Datapath side: reports hazard sources, obeys the controls
  modport master (
    output rs_rr, rt_rr, use_rs_rr, use_rt_rr, memread_ex, dest_ex,
           jump_ex, mem_req, mem_ready,
    input  pc_en, ifid_en, idrr_en, rrex_en, exmem_en, memwb_en,
           ifid_flush, idrr_flush, rrex_bubble, memwb_bubble, pc_sel_jump,
           stall_cycles, mem_timeout
  );

  // Controller side
  modport slave (
    input  rs_rr, rt_rr, use_rs_rr, use_rt_rr, memread_ex, dest_ex,
           jump_ex, mem_req, mem_ready,
    output pc_en, ifid_en, idrr_en, rrex_en, exmem_en, memwb_en,
           ifid_flush, idrr_flush, rrex_bubble, memwb_bubble, pc_sel_jump,
           stall_cycles, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 6-stage pipeline (IF,ID,RR,EX,MEM,WB).
// Data-memory waits freeze everything, EX jumps flush the front end,
// load-use hazards insert LOAD_STALL_CYCLES bubbles into RR/EX.
module pipe_hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MEM_WAIT_MAX      = 15
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN,
    LDSTALL,
    MEMWAIT
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  lcnt_q, lcnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic        mem_timeout_q, mem_timeout_d;

  logic hazard;
  logic memwait;
  logic stalled;

  assign hazard = bus.memread_ex && (bus.dest_ex != 5'd0) &&
                  ((bus.use_rs_rr && (bus.rs_rr == bus.dest_ex)) ||
                   (bus.use_rt_rr && (bus.rt_rr == bus.dest_ex)));
  assign memwait = bus.mem_req && !bus.mem_ready;

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.mem_timeout  = mem_timeout_q;

  // Next-state and same-cycle stage controls; a nonzero lcnt means load bubbles are still owed
  always_comb begin
    state_d          = state_q;
    lcnt_d           = lcnt_q;
    wait_cnt_d       = wait_cnt_q;
    mem_timeout_d    = mem_timeout_q;
    stall_cycles_d   = stall_cycles_q;
    stalled          = 1'b0;
    bus.pc_en        = 1'b1;
    bus.ifid_en      = 1'b1;
    bus.idrr_en      = 1'b1;
    bus.rrex_en      = 1'b1;
    bus.exmem_en     = 1'b1;
    bus.memwb_en     = 1'b1;
    bus.ifid_flush   = 1'b0;
    bus.idrr_flush   = 1'b0;
    bus.rrex_bubble  = 1'b0;
    bus.memwb_bubble = 1'b0;
    bus.pc_sel_jump  = 1'b0;

    if (!rst) begin
      bus.pc_en        = 1'b0;
      bus.ifid_flush   = 1'b1;
      bus.idrr_flush   = 1'b1;
      bus.rrex_bubble  = 1'b1;
      bus.memwb_bubble = 1'b1;
      state_d          = RUN;
      lcnt_d           = 3'd0;
      wait_cnt_d       = 8'd0;
      mem_timeout_d    = 1'b0;
      stall_cycles_d   = 16'd0;
    end else if (memwait) begin
      bus.pc_en        = 1'b0;
      bus.ifid_en      = 1'b0;
      bus.idrr_en      = 1'b0;
      bus.rrex_en      = 1'b0;
      bus.exmem_en     = 1'b0;
      bus.memwb_bubble = 1'b1;
      stalled          = 1'b1;
      state_d          = MEMWAIT;
      if (wait_cnt_q != 8'hFF) begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
      if (wait_cnt_d >= 8'(MEM_WAIT_MAX)) begin
        mem_timeout_d = 1'b1;
      end
    end else begin
      wait_cnt_d = 8'd0;
      if (bus.jump_ex) begin
        bus.pc_sel_jump = 1'b1;
        bus.ifid_flush  = 1'b1;
        bus.idrr_flush  = 1'b1;
        bus.rrex_bubble = 1'b1;
        lcnt_d          = 3'd0;
        state_d         = RUN;
      end else if (lcnt_q != 3'd0) begin
        bus.pc_en       = 1'b0;
        bus.ifid_en     = 1'b0;
        bus.idrr_en     = 1'b0;
        bus.rrex_bubble = 1'b1;
        stalled         = 1'b1;
        lcnt_d          = lcnt_q - 3'd1;
        state_d         = (lcnt_q == 3'd1) ? RUN : LDSTALL;
      end else if (hazard) begin
        bus.pc_en       = 1'b0;
        bus.ifid_en     = 1'b0;
        bus.idrr_en     = 1'b0;
        bus.rrex_bubble = 1'b1;
        stalled         = 1'b1;
        if (LOAD_STALL_CYCLES > 1) begin
          lcnt_d  = 3'(LOAD_STALL_CYCLES - 1);
          state_d = LDSTALL;
        end else begin
          state_d = RUN;
        end
      end else begin
        state_d = RUN;
      end
    end

    if (stalled && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= RUN;
      lcnt_q         <= 3'd0;
      wait_cnt_q     <= 8'd0;
      stall_cycles_q <= 16'd0;
      mem_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      lcnt_q         <= lcnt_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      mem_timeout_q  <= mem_timeout_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two instances (1 and 3 load
// bubbles, watchdog limits 15 and 2) share the same stimulus and are
// compared each cycle against a bubble-count reference model.
module tb_pipe_hazard_ctrl;

  typedef struct {
    bit       rst;
    bit [4:0] rs;
    bit [4:0] rt;
    bit [4:0] dest;
    bit       use_rs;
    bit       use_rt;
    bit       memread;
    bit       jump;
    bit       req;
    bit       ready;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pipe_hazard_ctrl_if bus0 ();
  pipe_hazard_ctrl_if bus1 ();

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_WAIT_MAX(15)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_WAIT_MAX(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected word: {mem_timeout, stall_cycles[15:0], ctl[10:0]}
  logic [27:0] exp_q0[$];
  logic [27:0] exp_q1[$];

  int bubbles_owed[2];
  int waited[2];
  int stalls[2];
  bit tmo[2];
  int lpar[2] = '{1, 3};
  int mpar[2] = '{15, 2};

  // ctl order: pc_en ifid_en idrr_en rrex_en exmem_en memwb_en ifid_flush idrr_flush rrex_bubble memwb_bubble pc_sel_jump
  function automatic logic [27:0] model_step(int i, stim_t s);
    logic [10:0] ctl;
    logic [27:0] word;
    bit is_hazard;
    is_hazard = s.memread && (s.dest != 0) &&
                ((s.use_rs && s.rs == s.dest) || (s.use_rt && s.rt == s.dest));
    if (!s.rst) begin
      ctl  = 11'b0_11111_1111_0;
      word = {tmo[i], 16'(stalls[i]), ctl};
      bubbles_owed[i] = 0;
      waited[i] = 0;
      stalls[i] = 0;
      tmo[i] = 1'b0;
      return word;
    end
    if (s.req && !s.ready) begin
      ctl = 11'b0_00001_0001_0;
      word = {tmo[i], 16'(stalls[i]), ctl};
      if (waited[i] < 255) waited[i]++;
      if (waited[i] >= mpar[i]) tmo[i] = 1'b1;
    end else begin
      waited[i] = 0;
      if (s.jump) begin
        ctl = 11'b1_11111_1110_1;
        bubbles_owed[i] = 0;
      end else if (bubbles_owed[i] > 0) begin
        ctl = 11'b0_00111_0010_0;
        bubbles_owed[i]--;
      end else if (is_hazard) begin
        ctl = 11'b0_00111_0010_0;
        bubbles_owed[i] = lpar[i] - 1;
      end else begin
        ctl = 11'b1_11111_0000_0;
      end
      word = {tmo[i], 16'(stalls[i]), ctl};
    end
    if (ctl[10] == 1'b0 && stalls[i] < 65535) stalls[i]++;
    return word;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1; s.rs = 5'd0; s.rt = 5'd0; s.dest = 5'd0;
    s.use_rs = 1'b0; s.use_rt = 1'b0; s.memread = 1'b0;
    s.jump = 1'b0; s.req = 1'b0; s.ready = 1'b0;
    return s;
  endfunction

  task automatic drive_bus(input stim_t s);
    rst = s.rst;
    bus0.rs_rr = s.rs;  bus1.rs_rr = s.rs;
    bus0.rt_rr = s.rt;  bus1.rt_rr = s.rt;
    bus0.dest_ex = s.dest;  bus1.dest_ex = s.dest;
    bus0.use_rs_rr = s.use_rs;  bus1.use_rs_rr = s.use_rs;
    bus0.use_rt_rr = s.use_rt;  bus1.use_rt_rr = s.use_rt;
    bus0.memread_ex = s.memread;  bus1.memread_ex = s.memread;
    bus0.jump_ex = s.jump;  bus1.jump_ex = s.jump;
    bus0.mem_req = s.req;  bus1.mem_req = s.req;
    bus0.mem_ready = s.ready;  bus1.mem_ready = s.ready;
  endtask

  // One cycle of stimulus: drive just after the edge, queue expectations
  task automatic apply_stimulus(input stim_t s);
    @(posedge clk);
    #1;
    drive_bus(s);
    exp_q0.push_back(model_step(0, s));
    exp_q1.push_back(model_step(1, s));
  endtask

  task automatic check_output(input int inst, input logic [27:0] exp_w, input logic [27:0] act_w);
    n_checks += 3;
    if (act_w[10:0] !== exp_w[10:0]) begin
      n_fail++;
      $display("[TB] FAIL dut%0d ctl @%0t actual=%b required=%b", inst, $time, act_w[10:0], exp_w[10:0]);
    end
    if (act_w[26:11] !== exp_w[26:11]) begin
      n_fail++;
      $display("[TB] FAIL dut%0d stall_cycles @%0t actual=%0d required=%0d", inst, $time, act_w[26:11], exp_w[26:11]);
    end
    if (act_w[27] !== exp_w[27]) begin
      n_fail++;
      $display("[TB] FAIL dut%0d mem_timeout @%0t actual=%b required=%b", inst, $time, act_w[27], exp_w[27]);
    end
  endtask

  function automatic logic [27:0] actual0();
    return {bus0.mem_timeout, bus0.stall_cycles, bus0.pc_en, bus0.ifid_en, bus0.idrr_en,
            bus0.rrex_en, bus0.exmem_en, bus0.memwb_en, bus0.ifid_flush, bus0.idrr_flush,
            bus0.rrex_bubble, bus0.memwb_bubble, bus0.pc_sel_jump};
  endfunction

  function automatic logic [27:0] actual1();
    return {bus1.mem_timeout, bus1.stall_cycles, bus1.pc_en, bus1.ifid_en, bus1.idrr_en,
            bus1.rrex_en, bus1.exmem_en, bus1.memwb_en, bus1.ifid_flush, bus1.idrr_flush,
            bus1.rrex_bubble, bus1.memwb_bubble, bus1.pc_sel_jump};
  endfunction

  // Monitor: compare whatever the controllers present mid-cycle against the queued expectation
  initial begin
    logic [27:0] e;
    forever begin
      @(negedge clk);
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        check_output(0, e, actual0());
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        check_output(1, e, actual1());
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic
  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b0;
    drive_bus(s);

    // Reset held for two cycles, then released
    apply_stimulus(s);
    apply_stimulus(s);
    apply_stimulus(idle());

    // Load-use on rs, one cycle of stimulus then idle
    s = idle(); s.memread = 1; s.dest = 5'd5; s.use_rs = 1; s.rs = 5'd5;
    apply_stimulus(s);
    repeat (4) apply_stimulus(idle());

    // Load-use on rt
    s = idle(); s.memread = 1; s.dest = 5'd7; s.use_rt = 1; s.rt = 5'd7; s.rs = 5'd7;
    apply_stimulus(s);
    repeat (3) apply_stimulus(idle());

    // Destination $zero never stalls
    s = idle(); s.memread = 1; s.dest = 5'd0; s.use_rs = 1; s.rs = 5'd0;
    apply_stimulus(s);
    apply_stimulus(idle());

    // Plain jump, then a jump landing inside the load stall
    s = idle(); s.jump = 1;
    apply_stimulus(s);
    s = idle(); s.memread = 1; s.dest = 5'd3; s.use_rs = 1; s.rs = 5'd3;
    apply_stimulus(s);
    s = idle(); s.jump = 1;
    apply_stimulus(s);
    repeat (2) apply_stimulus(idle());

    // Memory wait for three cycles with a pending jump, then release
    s = idle(); s.req = 1; s.ready = 0; s.jump = 1;
    repeat (3) apply_stimulus(s);
    s.ready = 1;
    apply_stimulus(s);
    repeat (2) apply_stimulus(idle());

    // Memory wait arriving during a load stall
    s = idle(); s.memread = 1; s.dest = 5'd9; s.use_rs = 1; s.rs = 5'd9;
    apply_stimulus(s);
    s = idle(); s.req = 1;
    repeat (2) apply_stimulus(s);
    repeat (3) apply_stimulus(idle());

    // Reset clears the sticky watchdog
    s = idle(); s.rst = 0;
    apply_stimulus(s);
    repeat (2) apply_stimulus(idle());

    // Randomized traffic with small register indices to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      s.rst     = ($urandom_range(0, 99) != 0);
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.dest    = 5'($urandom_range(0, 3));
      s.use_rs  = 1'($urandom_range(0, 1));
      s.use_rt  = 1'($urandom_range(0, 1));
      s.memread = 1'($urandom_range(0, 1));
      s.jump    = ($urandom_range(0, 7) == 0);
      s.req     = ($urandom_range(0, 2) == 0);
      s.ready   = 1'($urandom_range(0, 1));
      apply_stimulus(s);
    end

    apply_stimulus(idle());
    @(negedge clk);
    #1;
    n_checks++;
    if ((exp_q0.size() + exp_q1.size()) != 0) begin
      n_fail++;
      $display("[TB] FAIL drain actual=%0d pending required=0", exp_q0.size() + exp_q1.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
